// File: rtl/hilo_ctrl_pkg.sv
// rtl/hilo_ctrl_pkg.sv - shared md_op and FSM encodings plus default parameters for the HI/LO controller
package hilo_ctrl_pkg;

  // E-stage multiply/divide op codes, also consumed by the decoder
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Controller FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  // Watchdog limit must cover the unit's longest latency plus two
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  // Any op that touches HI/LO or the multiply/divide unit; codes 9..15 act as none
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MFLO);
  endfunction

  function automatic logic is_mf_op(input logic [3:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// rtl/hilo_ctrl_if.sv - pipeline/muldiv side bundle of the HI/LO controller
interface hilo_ctrl_if;

  logic [3:0]  md_op;
  logic [31:0] wdata;
  logic        start;
  logic        busy;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  // Pipeline and multiply/divide unit side
  modport master (
    output md_op, wdata, start, busy, hi_res, lo_res,
    input  stall, rdata, hi, lo, err
  );

  // HI/LO controller side
  modport slave (
    input  md_op, wdata, start, busy, hi_res, lo_res,
    output stall, rdata, hi, lo, err
  );

endinterface

// File: rtl/hilo_wdog.sv
// rtl/hilo_wdog.sv - RUN-state cycle counter with sticky timeout flag
module hilo_wdog
  import hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,      // the FSM enters RUN at the coming edge
  input  logic run_i,      // the FSM is in RUN this cycle
  output logic timeout_o,  // this RUN cycle is the last one allowed
  output logic err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The count reaches TIMEOUT at the edge that ends the TIMEOUT-th RUN cycle
  assign timeout_o = run_i && (cnt_q == CNT_LAST);
  assign err_o     = err_q;

  // Next-state: clear on RUN entry, count RUN cycles, saturate, latch err
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_o;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and sticky error registers; only reset clears err
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register owner and mult/div stall controller; HILO_FWD_EN forwards results to mfhi/mflo in CAPT
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  hilo_ctrl_if.slave bus
);

  state_e      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        run_first_q;

  logic        busy_any;
  logic        md_any;
  logic        mf_in_capt;
  logic        stall;
  logic [31:0] hi_src;
  logic [31:0] lo_src;
  logic [31:0] rdata;
  logic        wd_timeout;
  logic        wd_err;
  logic        wd_clr;
  logic        wd_run;

  // Stall while a multiply/divide is in flight or being issued this cycle
  always_comb begin
    busy_any = (state_q != S_IDLE) | bus.start;
    md_any   = is_md_op(bus.md_op);
`ifdef HILO_FWD_EN
    mf_in_capt = (state_q == S_CAPT) & is_mf_op(bus.md_op);
`else
    mf_in_capt = 1'b0;
`endif
    // Held low during reset so a stray start cannot freeze the pipeline
    stall = reset & busy_any & md_any & ~mf_in_capt;
  end

  // mfhi/mflo read data; in CAPT with forwarding the unit's outputs bypass HI/LO
  always_comb begin
    hi_src = hi_q;
    lo_src = lo_q;
`ifdef HILO_FWD_EN
    if (state_q == S_CAPT) begin
      hi_src = bus.hi_res;
      lo_src = bus.lo_res;
    end
`endif
    if (bus.md_op == MD_MFHI) begin
      rdata = hi_src;
    end else if (bus.md_op == MD_MFLO) begin
      rdata = lo_src;
    end else begin
      rdata = '0;
    end
  end

  // Watchdog restarts whenever start moves the FSM into RUN
  assign wd_clr = bus.start & (state_q != S_RUN);
  assign wd_run = (state_q == S_RUN);

  hilo_wdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (wd_clr),
    .run_i     (wd_run),
    .timeout_o (wd_timeout),
    .err_o     (wd_err)
  );

  // Controller FSM together with the architectural HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      run_first_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // start wins over an mt in the same cycle; the pipeline replays it
            state_q     <= S_RUN;
            run_first_q <= 1'b1;
          end else if (!stall) begin
            if (bus.md_op == MD_MTHI) hi_q <= bus.wdata;
            if (bus.md_op == MD_MTLO) lo_q <= bus.wdata;
          end
        end
        S_RUN: begin
          // busy may rise one cycle after start, so it is ignored on entry
          run_first_q <= 1'b0;
          if (wd_timeout) begin
            state_q <= S_IDLE;
          end else if (!run_first_q && !bus.busy) begin
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          hi_q <= bus.hi_res;
          lo_q <= bus.lo_res;
          if (bus.start) begin
            state_q     <= S_RUN;
            run_first_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall = stall;
  assign bus.rdata = rdata;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.err   = wd_err;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - randomized self-checking bench for hilo_ctrl against a timeline model
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int TIMEOUT = 64;
`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_ctrl_if bus ();

  hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  // Inputs change 1 time unit after the rising edge, outputs are sampled 2 later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // An op issued at phase 0 with busy high for phases 1..lat occupies the unit
  // through phase lat+1 (busy seen low) and phase lat+2 (capture).
  function automatic bit exp_stall(input int phase, input int lat, input logic [3:0] op);
    bit md, inflight, fwd_free;
    md       = (op >= 4'd1) && (op <= 4'd8);
    inflight = (phase >= 0) && (phase <= lat + 2);
    fwd_free = FWD && (phase == lat + 2) && ((op == 4'd7) || (op == 4'd8));
    return md && inflight && !fwd_free;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1; bus.busy = 1'b1; bus.md_op = 4'd7;
    bus.hi_res = $urandom; bus.lo_res = $urandom; bus.wdata = $urandom;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.rdata, 32'h0); end
    step();
    bus.start = 1'b0; bus.busy = 1'b0; bus.md_op = 4'd0;
    reset = 1'b1;
    step();
    bus.md_op = 4'd5; bus.wdata = 32'h1234_5678;
    settle();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus.stall); end
    step();
    bus.md_op = 4'd8;
    settle();
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected %h", bus.hi, 32'h1234_5678); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL mflo_after_reset: got %h expected %h", bus.rdata, 32'h0); end
    m_hi = 32'h1234_5678;
    m_lo = 32'h0;
  endtask

  task automatic test_div();
    int lat;
    logic [3:0] op;
    lat = 10;
    bus.hi_res = 32'd0; bus.lo_res = 32'd4;
    for (int p = 0; p <= lat + 2; p++) begin
      step();
      bus.start = (p == 0);
      bus.busy  = (p >= 1) && (p <= lat);
      op = (p == 0) ? 4'd3 : 4'($urandom_range(1, 8));
      bus.md_op = op; bus.wdata = $urandom;
      settle();
      checks++;
      if (bus.stall !== exp_stall(p, lat, op)) begin
        errors++; $display("FAIL div_stall p=%0d op=%0d: got %b expected %b", p, op, bus.stall, exp_stall(p, lat, op));
      end
    end
    step();
    bus.start = 1'b0; bus.busy = 1'b0; bus.md_op = 4'd8;
    settle();
    checks++; if (bus.lo !== 32'd4) begin errors++; $display("FAIL div_lo: got %h expected %h", bus.lo, 32'd4); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL div_hi: got %h expected %h", bus.hi, 32'd0); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL div_mflo_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.rdata !== 32'd4) begin errors++; $display("FAIL div_mflo_rdata: got %h expected %h", bus.rdata, 32'd4); end
    m_hi = 32'd0; m_lo = 32'd4;
  endtask

  task automatic test_mfhi_wait();
    int lat;
    logic [31:0] r_hi, r_lo;
    bit es;
    lat = $urandom_range(3, 8);
    r_hi = $urandom; r_lo = $urandom;
    bus.hi_res = r_hi; bus.lo_res = r_lo;
    for (int p = 0; p <= lat + 3; p++) begin
      step();
      bus.start = (p == 0);
      bus.busy  = (p >= 1) && (p <= lat);
      bus.md_op = (p == 0) ? 4'd1 : 4'd7;
      settle();
      es = exp_stall(p, lat, bus.md_op);
      checks++;
      if (bus.stall !== es) begin errors++; $display("FAIL mfhi_wait_stall p=%0d: got %b expected %b", p, bus.stall, es); end
      if (!es && p > 0) begin
        checks++;
        if (bus.rdata !== r_hi) begin errors++; $display("FAIL mfhi_wait_rdata p=%0d: got %h expected %h", p, bus.rdata, r_hi); end
      end
    end
    m_hi = r_hi; m_lo = r_lo;
  endtask

  task automatic test_mt_with_start();
    int lat;
    logic [31:0] r_lo;
    lat = 4;
    r_lo = $urandom;
    step();
    bus.start = 1'b1; bus.busy = 1'b0; bus.md_op = 4'd6; bus.wdata = 32'hAA;
    bus.hi_res = m_hi; bus.lo_res = $urandom;
    settle();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mt_start_stall: got %b expected 1", bus.stall); end
    step();
    bus.start = 1'b0; bus.busy = 1'b1; bus.md_op = 4'd0;
    settle();
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL mt_start_lo_kept: got %h expected %h", bus.lo, m_lo); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mt_start_nonmd_stall: got %b expected 0", bus.stall); end
    bus.md_op = 4'd1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mt_start_in_run: got %b expected 1", bus.stall); end
    for (int p = 2; p <= lat + 2; p++) begin
      step();
      bus.busy = (p <= lat);
      bus.lo_res = (p == lat + 2) ? r_lo : $urandom;
    end
    step();
    bus.md_op = 4'd0; bus.busy = 1'b0;
    settle();
    checks++; if (bus.lo !== r_lo) begin errors++; $display("FAIL mt_start_lo_final: got %h expected %h", bus.lo, r_lo); end
    m_lo = r_lo;
  endtask

  task automatic test_random_ops();
    int gap, lat;
    logic [3:0] op;
    logic [31:0] cap_hi, cap_lo, exp_rd;
    bit es;
    for (int n = 0; n < 16; n++) begin
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        bus.start = 1'b0; bus.busy = 1'b0;
        op = 4'($urandom_range(0, 15));
        bus.md_op = op; bus.wdata = $urandom; bus.hi_res = $urandom; bus.lo_res = $urandom;
        settle();
        exp_rd = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
        checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL rand_hi n=%0d: got %h expected %h", n, bus.hi, m_hi); end
        checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL rand_lo n=%0d: got %h expected %h", n, bus.lo, m_lo); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rand_idle_stall n=%0d: got %b expected 0", n, bus.stall); end
        checks++; if (bus.rdata !== exp_rd) begin errors++; $display("FAIL rand_idle_rdata n=%0d op=%0d: got %h expected %h", n, op, bus.rdata, exp_rd); end
        if (op == 4'd5) m_hi = bus.wdata;
        if (op == 4'd6) m_lo = bus.wdata;
      end
      lat = $urandom_range(1, 12);
      cap_hi = m_hi; cap_lo = m_lo;
      for (int p = 0; p <= lat + 2; p++) begin
        step();
        bus.start = (p == 0);
        bus.busy  = (p >= 1) && (p <= lat);
        op = (p == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
        bus.md_op = op; bus.wdata = $urandom; bus.hi_res = $urandom; bus.lo_res = $urandom;
        if (p == lat + 2) begin cap_hi = bus.hi_res; cap_lo = bus.lo_res; end
        settle();
        es = exp_stall(p, lat, op);
        checks++;
        if (bus.stall !== es) begin errors++; $display("FAIL rand_stall n=%0d p=%0d op=%0d: got %b expected %b", n, p, op, bus.stall, es); end
        if (!es) begin
          exp_rd = 32'h0;
          if (op == 4'd7) exp_rd = (p == lat + 2) ? bus.hi_res : m_hi;
          if (op == 4'd8) exp_rd = (p == lat + 2) ? bus.lo_res : m_lo;
          checks++;
          if (bus.rdata !== exp_rd) begin errors++; $display("FAIL rand_busy_rdata n=%0d p=%0d: got %h expected %h", n, p, bus.rdata, exp_rd); end
        end
      end
      m_hi = cap_hi; m_lo = cap_lo;
    end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_back_to_back();
    int a, b, q, total;
    logic [31:0] h1, l1, h2, l2;
    logic [3:0] op;
    bit es;
    a = $urandom_range(1, 6); b = $urandom_range(1, 6);
    h1 = $urandom; l1 = $urandom; h2 = $urandom; l2 = $urandom;
    total = a + 2 + b + 2;
    for (int p = 0; p <= total; p++) begin
      q = p - (a + 2);
      step();
      bus.start = (p == 0) || (q == 0);
      bus.busy  = ((p >= 1) && (p <= a)) || ((q >= 1) && (q <= b));
      op = (p == 0 || q == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      bus.md_op = op;
      bus.hi_res = (q == 0) ? h1 : (p == total) ? h2 : $urandom;
      bus.lo_res = (q == 0) ? l1 : (p == total) ? l2 : $urandom;
      settle();
      es = (q < 0) ? exp_stall(p, a, op) : exp_stall(q, b, op);
      checks++;
      if (bus.stall !== es) begin errors++; $display("FAIL b2b_stall p=%0d op=%0d: got %b expected %b", p, op, bus.stall, es); end
      if (q == 1) begin
        checks++; if (bus.hi !== h1) begin errors++; $display("FAIL b2b_first_hi: got %h expected %h", bus.hi, h1); end
        checks++; if (bus.lo !== l1) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", bus.lo, l1); end
      end
    end
    step();
    bus.start = 1'b0; bus.busy = 1'b0; bus.md_op = 4'd0;
    settle();
    checks++; if (bus.hi !== h2) begin errors++; $display("FAIL b2b_second_hi: got %h expected %h", bus.hi, h2); end
    checks++; if (bus.lo !== l2) begin errors++; $display("FAIL b2b_second_lo: got %h expected %h", bus.lo, l2); end
    m_hi = h2; m_lo = l2;
  endtask

  task automatic test_watchdog();
    step();
    bus.start = 1'b1; bus.busy = 1'b0; bus.md_op = 4'd4;
    settle();
    for (int r = 1; r <= TIMEOUT; r++) begin
      step();
      bus.start = 1'b0; bus.busy = 1'b1; bus.md_op = 4'd7;
      bus.hi_res = $urandom; bus.lo_res = $urandom;
      settle();
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wdog_run_stall r=%0d: got %b expected 1", r, bus.stall); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wdog_early_err r=%0d: got %b expected 0", r, bus.err); end
    end
    step();
    settle();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL wdog_err: got %b expected 1", bus.err); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL wdog_idle_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL wdog_hi: got %h expected %h", bus.hi, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL wdog_lo: got %h expected %h", bus.lo, m_lo); end
    checks++; if (bus.rdata !== m_hi) begin errors++; $display("FAIL wdog_rdata: got %h expected %h", bus.rdata, m_hi); end
    repeat (3) step();
    bus.busy = 1'b0; bus.md_op = 4'd0;
    settle();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", bus.err); end
  endtask

  task automatic test_reset_mid_run();
    step();
    bus.start = 1'b1; bus.busy = 1'b0; bus.md_op = 4'd3;
    bus.hi_res = $urandom | 32'h1; bus.lo_res = $urandom | 32'h1;
    step();
    bus.start = 1'b0; bus.busy = 1'b1; bus.md_op = 4'd7;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrun_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrun_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midrun_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrun_err: got %b expected 0", bus.err); end
    step();
    reset = 1'b1; bus.busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      bus.md_op = (c[0]) ? 4'd8 : 4'd7;
      settle();
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midrun_after_stall c=%0d: got %b expected 0", c, bus.stall); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrun_after_hi c=%0d: got %h expected %h", c, bus.hi, 32'h0); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrun_after_lo c=%0d: got %h expected %h", c, bus.lo, 32'h0); end
    end
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    bus.md_op = 4'd0; bus.wdata = '0; bus.start = 1'b0; bus.busy = 1'b0;
    bus.hi_res = '0; bus.lo_res = '0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_div();
    test_mfhi_wait();
    test_mt_with_start();
    test_random_ops();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
